// File: rtl/div_mc.sv
// div_mc: multi-cycle unsigned restoring divider producing one quotient bit per clock
module div_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   sh, diff;
  logic             ge, go;
  // Next-state: operand capture on an accepted start, otherwise one restoring step per RUN cycle.
  // A set top bit in the shifted remainder already means it exceeds the divisor, so the
  // WIDTH+1-bit difference never needs a wider sign.
  always_comb begin
    go      = start && (state_q != RUN);
    sh      = {rem_q, quo_q[WIDTH-1]};
    diff    = sh - {1'b0, div_q};
    ge      = sh[WIDTH] | ~diff[WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    if (go) begin
      if (b == '0) begin
        quo_d   = '1;
        rem_d   = a;
        dbz_d   = 1'b1;
        state_d = DONE;
      end else begin
        quo_d   = a;
        div_d   = b;
        rem_d   = '0;
        cnt_d   = '0;
        dbz_d   = 1'b0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      rem_d   = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = quo_q;
  assign r    = rem_q;
  assign dbz  = dbz_q;
endmodule
